// File: rtl/bcd_timer_ctrl.sv
// Command-driven sequencer for a cascade of BCD digit counters: prescaled ticks,
// start/pause/clear FSM, and stop-or-reload on a latched BCD target.
module bcd_timer_ctrl #(
  parameter int DIGITS      = 4,
  parameter int PRESCALE    = 10,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   target,
  output logic [4*DIGITS-1:0]   count,
  output logic [1:0]            state,
  output logic                  busy,
  output logic                  tick,
  output logic                  done,
  output logic                  err
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   target_q, target_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            busy_q, busy_d;
  logic            tick_q, tick_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [CW-1:0]   inc_s;
  logic            step_s;

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry && (v[4*i +: 4] == 4'd9)) begin
        r[4*i +: 4] = 4'd0;
      end else if (carry) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        carry       = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [CW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Next-state: command decode (clear > start > pause), then prescaler/count advance.
  // Resuming from PAUSE advances on the resume edge, so a P-cycle pause delays by exactly P.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    presc_d  = presc_q;
    target_d = target_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    step_s   = 1'b0;
    inc_s    = bcd_inc(count_q);
    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && bcd_ok(target)) begin
            target_d = target;
            count_d  = '0;
            presc_d  = '0;
            if ((target == '0) && (AUTO_RELOAD == 0)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else if (start) begin
            err_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else begin
            step_s = 1'b1;
          end
        end
        S_PAUSE: begin
          if (start) begin
            state_d = S_RUN;
            step_s  = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (step_s && (presc_q == PS_LAST)) begin
        presc_d = '0;
        tick_d  = 1'b1;
        // An all-zero target only reaches RUN with reload, where it matches every tick.
        if ((inc_s == target_q) || (target_q == '0)) begin
          done_d = 1'b1;
          if (AUTO_RELOAD != 0) begin
            count_d = '0;
          end else begin
            count_d = target_q;
            state_d = S_DONE;
          end
        end else begin
          count_d = inc_s;
        end
      end else if (step_s) begin
        presc_d = presc_q + PW'(1);
      end else begin
        presc_d = presc_d;
      end
    end
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      target_q <= '0;
      presc_q  <= '0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      presc_q  <= presc_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = busy_q;
  assign tick  = tick_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl: vector table plus multi-cycle sequences on three configurations.
module tb_bcd_timer_ctrl;

  logic clk;
  logic RST;

  logic st0, pa0, cl0, bs0, tk0, dn0, er0;
  logic [7:0] tg0, cn0;
  logic [1:0] sa0;
  logic st1, pa1, cl1, bs1, tk1, dn1, er1;
  logic [7:0] tg1, cn1;
  logic [1:0] sa1;
  logic st2, pa2, cl2, bs2, tk2, dn2, er2;
  logic [7:0] tg2, cn2;
  logic [1:0] sa2;

  int passed = 0;
  int total  = 0;

  bcd_timer_ctrl #(.DIGITS(2), .PRESCALE(3), .AUTO_RELOAD(0)) u0 (
    .clk(clk), .RST(RST), .start(st0), .pause(pa0), .clear(cl0), .target(tg0),
    .count(cn0), .state(sa0), .busy(bs0), .tick(tk0), .done(dn0), .err(er0));

  bcd_timer_ctrl #(.DIGITS(2), .PRESCALE(3), .AUTO_RELOAD(1)) u1 (
    .clk(clk), .RST(RST), .start(st1), .pause(pa1), .clear(cl1), .target(tg1),
    .count(cn1), .state(sa1), .busy(bs1), .tick(tk1), .done(dn1), .err(er1));

  bcd_timer_ctrl #(.DIGITS(2), .PRESCALE(1), .AUTO_RELOAD(0)) u2 (
    .clk(clk), .RST(RST), .start(st2), .pause(pa2), .clear(cl2), .target(tg2),
    .count(cn2), .state(sa2), .busy(bs2), .tick(tk2), .done(dn2), .err(er2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       st;
    logic       pa;
    logic       cl;
    logic [7:0] tg;
    logic [7:0] ecnt;
    logic [1:0] est;
    logic       ebusy;
    logic       etick;
    logic       edone;
    logic       eerr;
  } vec_t;

  vec_t vt [28];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic chk0(input string nm, input logic [7:0] ec, input logic [1:0] es,
                      input logic eb, input logic et, input logic ed, input logic ee);
    chk({nm, " count"}, 32'(cn0), 32'(ec));
    chk({nm, " state"}, 32'(sa0), 32'(es));
    chk({nm, " busy"},  32'(bs0), 32'(eb));
    chk({nm, " tick"},  32'(tk0), 32'(et));
    chk({nm, " done"},  32'(dn0), 32'(ed));
    chk({nm, " err"},   32'(er0), 32'(ee));
  endtask

  initial begin
    int a;
    int early;
    // start pause clear target | count state busy tick done err
    vt[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 8'h1A, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 8'h07, 8'h01, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 8'h07, 8'h01, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[16] = '{1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[18] = '{1'b1, 1'b0, 1'b1, 8'h05, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[20] = '{1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[21] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[22] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[23] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[24] = '{1'b1, 1'b0, 1'b0, 8'h05, 8'h01, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[25] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[26] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[27] = '{1'b1, 1'b0, 1'b0, 8'h9F, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1};

    RST = 1'b0;
    {st0, pa0, cl0, tg0} = '0;
    {st1, pa1, cl1, tg1} = '0;
    {st2, pa2, cl2, tg2} = '0;
    #12;
    chk0("reset", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    step();

    for (int i = 0; i < 28; i++) begin
      st0 = vt[i].st; pa0 = vt[i].pa; cl0 = vt[i].cl; tg0 = vt[i].tg;
      step();
      chk0($sformatf("vec%0d", i), vt[i].ecnt, vt[i].est, vt[i].ebusy, vt[i].etick,
           vt[i].edone, vt[i].eerr);
    end
    {st0, pa0, cl0, tg0} = '0;

    // Run to 0x12 from DONE: one increment every 3 edges, done after edge 36.
    st0 = 1'b1; tg0 = 8'h12;
    step();
    st0 = 1'b0; tg0 = 8'h00;
    for (int n = 1; n <= 37; n++) begin
      step();
      a = (n > 36) ? 36 : n;
      chk0($sformatf("run12 e%0d", n), to_bcd(a / 3), (n >= 36) ? 2'd3 : 2'd1,
           n < 36, (n % 3 == 0) && (n <= 36), n == 36, 1'b0);
    end

    // Pause at 05 for 10 edges; target changed after acceptance must be ignored.
    st0 = 1'b1; tg0 = 8'h12;
    step();
    st0 = 1'b0; tg0 = 8'h03;
    for (int n = 1; n <= 47; n++) begin
      pa0 = (n >= 16) && (n <= 25);
      st0 = (n == 26);
      step();
      a = (n <= 15) ? n : ((n <= 25) ? 15 : n - 10);
      if (a > 36) a = 36;
      chk({$sformatf("pause e%0d", n), " count"}, 32'(cn0), 32'(to_bcd(a / 3)));
      chk({$sformatf("pause e%0d", n), " state"}, 32'(sa0),
          (n >= 16 && n <= 25) ? 32'd2 : ((a == 36) ? 32'd3 : 32'd1));
      chk({$sformatf("pause e%0d", n), " done"}, 32'(dn0), 32'(n == 46));
    end
    {st0, pa0, tg0} = '0;

    // Full range 0x99: done exactly after edge 297.
    st0 = 1'b1; tg0 = 8'h99;
    step();
    st0 = 1'b0; tg0 = 8'h00;
    early = 0;
    for (int n = 1; n < 297; n++) begin
      step();
      if (dn0 !== 1'b0) early++;
      if (n == 30) chk("run99 carry 10", 32'(cn0), 32'h10);
    end
    chk("run99 early done", 32'(early), 32'd0);
    step();
    chk0("run99 end", 8'h99, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);

    // Auto-reload, target 03: 01,02,00 repeating, done every 9 edges.
    st1 = 1'b1; tg1 = 8'h03;
    step();
    st1 = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      step();
      chk($sformatf("reload e%0d count", n), 32'(cn1), 32'(to_bcd((n / 3) % 3)));
      chk($sformatf("reload e%0d done", n), 32'(dn1), 32'(n % 9 == 0));
      chk($sformatf("reload e%0d state", n), 32'(sa1), 32'd1);
    end

    // PRESCALE=1, target 02.
    st2 = 1'b1; tg2 = 8'h02;
    step();
    st2 = 1'b0;
    chk("p1 e0 state", 32'(sa2), 32'd1);
    step();
    chk("p1 e1 count", 32'(cn2), 32'h01);
    chk("p1 e1 tick", 32'(tk2), 32'd1);
    chk("p1 e1 done", 32'(dn2), 32'd0);
    step();
    chk("p1 e2 count", 32'(cn2), 32'h02);
    chk("p1 e2 tick", 32'(tk2), 32'd1);
    chk("p1 e2 done", 32'(dn2), 32'd1);
    chk("p1 e2 state", 32'(sa2), 32'd3);
    step();
    chk("p1 e3 done", 32'(dn2), 32'd0);

    // Asynchronous reset mid-count, then first command after release.
    st0 = 1'b1; tg0 = 8'h99;
    step();
    st0 = 1'b0;
    for (int n = 0; n < 10; n++) step();
    chk("pre-reset count", 32'(cn0), 32'h03);
    #2;
    RST = 1'b0;
    #1;
    chk0("async reset", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    RST = 1'b1;
    st0 = 1'b1; tg0 = 8'h01;
    step();
    st0 = 1'b0;
    chk("post-reset start state", 32'(sa0), 32'd1);
    chk("post-reset start busy", 32'(bs0), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
